// File: rtl/spi_shift_engine.sv
// SPI master shift engine: AVR-style sck prescaler, one BIT_WIDTH word per transfer.
// Optional build macro SPI_LOOPBACK_EN adds a loopback input that samples mosi instead of miso.
module spi_shift_engine #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 spe,
    input  logic                 dord,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic [2:0]           clock_rate,
    input  logic [BIT_WIDTH-1:0] txb,
    input  logic                 set_spdr,
    input  logic                 miso,
`ifdef SPI_LOOPBACK_EN
    input  logic                 loopback,
`endif
    output logic [BIT_WIDTH-1:0] rxb,
    output logic                 txc,
    output logic                 transfor,
    output logic                 sck,
    output logic                 mosi
);

    localparam int KW = $clog2(2 * BIT_WIDTH);
    localparam logic [KW-1:0] EDGE_LAST = KW'(2 * BIT_WIDTH - 1);
    localparam logic [KW-1:0] EDGE_STEP = {{(KW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state_r;
    logic [5:0]             div_r;
    logic [5:0]             half_r;
    logic [KW-1:0]          edge_r;
    logic [BIT_WIDTH-1:0]   tx_r;
    logic [BIT_WIDTH-1:0]   rx_r;
    logic                   dord_r;
    logic                   cpol_r;
    logic                   cpha_r;
`ifdef SPI_LOOPBACK_EN
    logic                   lb_r;
`endif

    logic                   sample_bit_s;
    logic                   edge_tick_s;
    logic                   last_edge_s;
    logic                   leading_s;

    // Half-period minus one, so the divider compares against a 0-based count.
    function automatic logic [5:0] half_minus_one(input logic [2:0] rate);
        logic [5:0] h;
        case (rate)
            3'b000:  h = 6'd1;
            3'b001:  h = 6'd7;
            3'b010:  h = 6'd31;
            3'b011:  h = 6'd63;
            3'b100:  h = 6'd0;
            3'b101:  h = 6'd3;
            3'b110:  h = 6'd15;
            3'b111:  h = 6'd31;
            default: h = 6'd1;
        endcase
        return h;
    endfunction

    function automatic logic out_bit(input logic [BIT_WIDTH-1:0] word, input logic lsb_first);
        logic b;
        if (lsb_first) begin
            b = word[0];
        end else begin
            b = word[BIT_WIDTH-1];
        end
        return b;
    endfunction

    function automatic logic [BIT_WIDTH-1:0] shift_out(input logic [BIT_WIDTH-1:0] word,
                                                       input logic lsb_first);
        logic [BIT_WIDTH-1:0] w;
        if (lsb_first) begin
            w = {1'b0, word[BIT_WIDTH-1:1]};
        end else begin
            w = {word[BIT_WIDTH-2:0], 1'b0};
        end
        return w;
    endfunction

    // Received bits enter at the end that leaves the word in native order after BIT_WIDTH samples.
    function automatic logic [BIT_WIDTH-1:0] shift_in(input logic [BIT_WIDTH-1:0] word,
                                                      input logic b, input logic lsb_first);
        logic [BIT_WIDTH-1:0] w;
        if (lsb_first) begin
            w = {b, word[BIT_WIDTH-1:1]};
        end else begin
            w = {word[BIT_WIDTH-2:0], b};
        end
        return w;
    endfunction

    // Serial input source selection.
    always_comb begin
        sample_bit_s = miso;
`ifdef SPI_LOOPBACK_EN
        if (lb_r) begin
            sample_bit_s = mosi;
        end else begin
            sample_bit_s = miso;
        end
`endif
    end

    // Divider terminal count and position of the current sck edge.
    always_comb begin
        edge_tick_s = (div_r == half_r);
        last_edge_s = (edge_r == EDGE_LAST);
        leading_s   = ~edge_r[0];
    end

    // Transfer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r  <= ST_IDLE;
            div_r    <= 6'd0;
            half_r   <= 6'd0;
            edge_r   <= '0;
            tx_r     <= '0;
            rx_r     <= '0;
            dord_r   <= 1'b0;
            cpol_r   <= 1'b0;
            cpha_r   <= 1'b0;
`ifdef SPI_LOOPBACK_EN
            lb_r     <= 1'b0;
`endif
            rxb      <= '0;
            txc      <= 1'b0;
            transfor <= 1'b0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
        end else begin
            txc <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    sck      <= cpol;
                    transfor <= 1'b0;
                    if (set_spdr && spe) begin
                        state_r  <= ST_SHIFT;
                        transfor <= 1'b1;
                        div_r    <= 6'd0;
                        edge_r   <= '0;
                        half_r   <= half_minus_one(clock_rate);
                        dord_r   <= dord;
                        cpol_r   <= cpol;
                        cpha_r   <= cpha;
                        rx_r     <= '0;
`ifdef SPI_LOOPBACK_EN
                        lb_r     <= loopback;
`endif
                        // With cpha=0 the first bit must already be on the line before the first edge.
                        if (cpha) begin
                            tx_r <= txb;
                        end else begin
                            tx_r <= shift_out(txb, dord);
                            mosi <= out_bit(txb, dord);
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!spe) begin
                        state_r  <= ST_IDLE;
                        sck      <= cpol;
                        transfor <= 1'b0;
                    end else if (edge_tick_s) begin
                        div_r  <= 6'd0;
                        sck    <= ~sck;
                        edge_r <= edge_r + EDGE_STEP;
                        if (leading_s != cpha_r) begin
                            rx_r <= shift_in(rx_r, sample_bit_s, dord_r);
                        end else if (cpha_r || !last_edge_s) begin
                            mosi <= out_bit(tx_r, dord_r);
                            tx_r <= shift_out(tx_r, dord_r);
                        end
                        if (last_edge_s) begin
                            state_r  <= ST_DONE;
                            transfor <= 1'b0;
                        end
                    end else begin
                        div_r <= div_r + 6'd1;
                    end
                end
                ST_DONE: begin
                    txc     <= 1'b1;
                    rxb     <= rx_r;
                    sck     <= cpol;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    transfor <= 1'b0;
                    sck      <= cpol;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: a transfer-level model checked every cycle,
// plus directed transfers with hand-computed expectations.
module tb_spi_shift_engine;

    localparam int W = 8;

    logic       clk        = 1'b0;
    logic       rst_       = 1'b0;
    logic       spe        = 1'b0;
    logic       dord       = 1'b0;
    logic       cpol       = 1'b0;
    logic       cpha       = 1'b0;
    logic [2:0] clock_rate = 3'b000;
    logic [7:0] txb        = 8'h00;
    logic       set_spdr   = 1'b0;
    logic       miso       = 1'b0;
    logic       loopback   = 1'b0;
    logic [7:0] rxb;
    logic       txc;
    logic       transfor;
    logic       sck;
    logic       mosi;

    logic [7:0] slave_word = 8'h00;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_shift_engine #(.BIT_WIDTH(W)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .spe        (spe),
        .dord       (dord),
        .cpol       (cpol),
        .cpha       (cpha),
        .clock_rate (clock_rate),
        .txb        (txb),
        .set_spdr   (set_spdr),
        .miso       (miso),
`ifdef SPI_LOOPBACK_EN
        .loopback   (loopback),
`endif
        .rxb        (rxb),
        .txc        (txc),
        .transfor   (transfor),
        .sck        (sck),
        .mosi       (mosi)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int h_of(input logic [2:0] r);
        case (r)
            3'd0:    return 2;
            3'd1:    return 8;
            3'd2:    return 32;
            3'd3:    return 64;
            3'd4:    return 1;
            3'd5:    return 4;
            3'd6:    return 16;
            default: return 32;
        endcase
    endfunction

    function automatic logic word_bit(input logic [7:0] w, input logic lsb_first, input int j);
        return lsb_first ? w[j] : w[W-1-j];
    endfunction

    // Transfer-level model: m_c counts clocks since the accepting edge.
    logic       m_busy = 1'b0;
    int         m_c = 0;
    int         m_h = 1;
    logic       m_cpol = 1'b0, m_cpha = 1'b0, m_dord = 1'b0;
    logic [7:0] m_tx = 8'h00, m_rx = 8'h00;
    logic       e_txc = 1'b0, e_transfor = 1'b0, e_sck = 1'b0, e_mosi = 1'b0;
    logic [7:0] e_rxb = 8'h00;

    initial begin
        int t;
        forever begin
            @(posedge clk);
            if (!rst_) begin
                m_busy = 1'b0; m_c = 0;
                e_txc = 1'b0; e_transfor = 1'b0; e_sck = 1'b0; e_mosi = 1'b0; e_rxb = 8'h00;
            end else begin
                e_txc = 1'b0;
                if (m_busy && m_c < 2*W*m_h && !spe) begin
                    m_busy = 1'b0;
                end else if (m_busy) begin
                    m_c++;
                    if (m_c == 2*W*m_h + 1) begin
                        m_busy = 1'b0;
                        e_txc  = 1'b1;
                        e_rxb  = m_rx;
                    end else if (m_c % m_h == 0) begin
                        t = m_c / m_h;
                        if (!m_cpha && (t % 2 == 0) && t < 2*W) e_mosi = word_bit(m_tx, m_dord, t/2);
                        if (m_cpha && (t % 2 == 1)) e_mosi = word_bit(m_tx, m_dord, (t-1)/2);
                    end
                end else if (set_spdr && spe) begin
                    m_busy = 1'b1; m_c = 0; m_h = h_of(clock_rate);
                    m_cpol = cpol; m_cpha = cpha; m_dord = dord; m_tx = txb;
                    m_rx = loopback ? txb : slave_word;
                    if (!cpha) e_mosi = word_bit(txb, dord, 0);
                end
                if (m_busy) begin
                    e_transfor = (m_c < 2*W*m_h);
                    t = (m_c / m_h < 2*W) ? m_c / m_h : 2*W;
                    e_sck = m_cpol ^ (t % 2 == 1);
                end else begin
                    e_transfor = 1'b0;
                    e_sck = cpol;
                end
            end
        end
    end

    // Slave: presents the next bit of slave_word ahead of each sampling edge.
    initial begin
        int t, s;
        forever begin
            @(negedge clk);
            if (m_busy) begin
                t = m_c / m_h;
                if (t > 2*W) t = 2*W;
                s = m_cpha ? t/2 : (t+1)/2;
                if (s < W) miso = word_bit(slave_word, m_dord, s);
            end else begin
                miso = word_bit(slave_word, dord, 0);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_) begin
                chk("transfor", transfor, e_transfor);
                chk("txc", txc, e_txc);
                chk("sck", sck, e_sck);
                chk("mosi", mosi, e_mosi);
                chk("rxb", rxb, e_rxb);
            end
        end
    end

    task automatic start_xfer(input logic [7:0] word);
        txb = word;
        set_spdr = 1'b1;
        @(negedge clk);
        set_spdr = 1'b0;
    endtask

    // Called at the first negedge after the accepting edge; returns when txc is seen or the budget expires.
    task automatic wait_done(input int budget, input logic cpha_i, input logic dord_i,
                             output int lat, output int tf, output int edges,
                             output int t1, output int t3, output logic [7:0] cap);
        logic prev;
        prev = sck; lat = 0; tf = 0; edges = 0; t1 = 0; t3 = 0; cap = 8'h00;
        while (txc !== 1'b1 && lat < budget) begin
            if (transfor) tf++;
            @(negedge clk);
            lat++;
            if (sck !== prev) begin
                prev = sck;
                edges++;
                if (edges == 1) t1 = lat;
                if (edges == 3) t3 = lat;
                if ((edges % 2 == 1) != cpha_i) cap = dord_i ? {mosi, cap[7:1]} : {cap[6:0], mosi};
            end
        end
        chk("txc_seen", txc, 1'b1);
    endtask

    initial begin
        int lat, tf, edges, t1, t3, cnt;
        logic [7:0] cap;

        repeat (3) @(negedge clk);
        chk("rst_rxb", rxb, 8'h00);
        chk("rst_txc", txc, 1'b0);
        chk("rst_transfor", transfor, 1'b0);
        chk("rst_sck", sck, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        rst_ = 1'b1;
        spe = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0, H=2, MSB first
        cpol = 1'b0; cpha = 1'b0; dord = 1'b0; clock_rate = 3'b000; slave_word = 8'h3C;
        @(negedge clk);
        start_xfer(8'hA5);
        wait_done(100, 1'b0, 1'b0, lat, tf, edges, t1, t3, cap);
        chk("m0_latency", lat, 33);
        chk("m0_transfor_cycles", tf, 32);
        chk("m0_edges", edges, 16);
        chk("m0_mosi_bits", cap, 8'hA5);
        chk("m0_rxb", rxb, 8'h3C);

        // Mode 3, H=1, LSB first
        cpol = 1'b1; cpha = 1'b1; dord = 1'b1; clock_rate = 3'b100; slave_word = 8'hFF;
        repeat (2) @(negedge clk);
        chk("m3_sck_idle", sck, 1'b1);
        start_xfer(8'h81);
        wait_done(100, 1'b1, 1'b1, lat, tf, edges, t1, t3, cap);
        chk("m3_latency", lat, 17);
        chk("m3_transfor_cycles", tf, 16);
        chk("m3_edges", edges, 16);
        chk("m3_mosi_bits", cap, 8'h81);
        chk("m3_rxb", rxb, 8'hFF);

        // Prescaler sweep
        cpol = 1'b0; cpha = 1'b0; dord = 1'b0; slave_word = 8'h96;
        for (int r = 0; r < 8; r++) begin
            clock_rate = 3'(r);
            @(negedge clk);
            start_xfer(8'h00);
            wait_done(16 * h_of(3'(r)) + 20, 1'b0, 1'b0, lat, tf, edges, t1, t3, cap);
            chk("sweep_latency", lat, 16 * h_of(3'(r)) + 1);
            chk("sweep_period", t3 - t1, 2 * h_of(3'(r)));
            chk("sweep_rxb", rxb, 8'h96);
        end

        // Abort by spe after edge 5
        cpol = 1'b1; clock_rate = 3'b000; slave_word = 8'h11;
        @(negedge clk);
        start_xfer(8'hC3);
        repeat (12) @(negedge clk);
        spe = 1'b0;
        @(negedge clk);
        chk("abort_transfor", transfor, 1'b0);
        chk("abort_sck", sck, 1'b1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (txc) cnt++;
        end
        chk("abort_no_txc", cnt, 0);
        chk("abort_rxb_kept", rxb, 8'h96);
        spe = 1'b1; cpol = 1'b0; slave_word = 8'h42;
        @(negedge clk);
        start_xfer(8'h3C);
        wait_done(100, 1'b0, 1'b0, lat, tf, edges, t1, t3, cap);
        chk("after_abort_latency", lat, 33);
        chk("after_abort_rxb", rxb, 8'h42);

        // set_spdr during an active transfer is ignored
        slave_word = 8'hE7;
        @(negedge clk);
        start_xfer(8'h5A);
        fork
            begin
                repeat (9) @(negedge clk);
                txb = 8'hFF;
                set_spdr = 1'b1;
                @(negedge clk);
                set_spdr = 1'b0;
            end
            wait_done(100, 1'b0, 1'b0, lat, tf, edges, t1, t3, cap);
        join
        chk("busy_start_latency", lat, 33);
        chk("busy_start_mosi", cap, 8'h5A);
        chk("busy_start_rxb", rxb, 8'hE7);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (transfor) cnt++;
        end
        chk("busy_start_no_second", cnt, 0);

        // Reset in the middle of a transfer
        @(negedge clk);
        start_xfer(8'hF0);
        repeat (10) @(negedge clk);
        chk("pre_rst_transfor", transfor, 1'b1);
        rst_ = 1'b0;
        #1;
        chk("mid_rst_transfor", transfor, 1'b0);
        chk("mid_rst_sck", sck, 1'b0);
        chk("mid_rst_mosi", mosi, 1'b0);
        chk("mid_rst_rxb", rxb, 8'h00);
        chk("mid_rst_txc", txc, 1'b0);
        @(negedge clk);
        rst_ = 1'b1;
        repeat (2) @(negedge clk);

`ifdef SPI_LOOPBACK_EN
        loopback = 1'b1; slave_word = 8'h00; dord = 1'b0; clock_rate = 3'b100;
        for (int m = 0; m < 4; m++) begin
            cpol = m[1]; cpha = m[0];
            repeat (2) @(negedge clk);
            start_xfer(8'h5A);
            wait_done(100, cpha, 1'b0, lat, tf, edges, t1, t3, cap);
            chk("loopback_rxb", rxb, 8'h5A);
        end
        loopback = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- SPI master serialiser/deserialiser downstream of the SPI register map; consumes its control outputs (spe, dord, cpol, cpha, clock_rate, txb, set_spdr).
- Returns rxb, txc and transfor to the register map.
- Generates sck from clk via an AVR-style prescaler and shifts one BIT_WIDTH word per transfer on mosi/miso; slave selects are outside this block.

Parameters:
BIT_WIDTH, 8, word length in bits; must match register_pkg::BIT_WIDTH

Ports:
clk  in  1  system clock
rst_  in  1  asynchronous active-low reset
spe  in  1  SPI enable; low aborts/blocks transfers
dord  in  1  1 = LSB first, 0 = MSB first
cpol  in  1  sck idle level
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge
clock_rate  in  3  {SPI2X, SPR[1:0]} prescaler select
txb  in  BIT_WIDTH  word to transmit
set_spdr  in  1  1-cycle start pulse; txb valid in same cycle
miso  in  1  serial data in
rxb  out  BIT_WIDTH  last received word
txc  out  1  1-cycle transfer-complete pulse
transfor  out  1  transfer in progress
sck  out  1  SPI clock
mosi  out  1  serial data out

Behaviour:
- Interface: one clock clk; reset rst_ is asynchronous, active-low. All outputs registered.
- Reset values: rxb=0, txc=0, transfor=0, sck=0, mosi=0, state=IDLE.
- Half-period H (clk cycles) from clock_rate:
  - SPI2X=0: SPR 00→2, 01→8, 10→32, 11→64 (÷4, ÷16, ÷64, ÷128).
  - SPI2X=1: SPR 00→1, 01→4, 10→16, 11→32 (÷2, ÷8, ÷32, ÷64).
- FSM IDLE → SHIFT → DONE → IDLE:
  - IDLE: sck=cpol (tracks live cpol), transfor=0.
  - IDLE → SHIFT: set_spdr & spe sampled high. Latch txb into the shift register; latch dord/cpol/cpha/H into working copies. transfor=1 from the next cycle.
  - Config inputs changing mid-transfer have no effect.
- SHIFT:
  - Divider counts 0..H-1; at H-1 sck toggles and the edge counter k increments. Edges k = 0..2*BIT_WIDTH-1.
  - Even k is the leading edge; odd k is the trailing edge.
  - cpha=0: first data bit on mosi in the first SHIFT cycle. Leading edges sample miso; trailing edges shift the next bit out.
  - cpha=1: leading edges shift a bit out (first bit driven at k=0); trailing edges sample miso.
  - Bit order: dord=0 sends/receives MSB first; dord=1 sends/receives LSB first. The received word is assembled in native bit order.
- SHIFT → DONE: after edge 2*BIT_WIDTH-1; sck is then back at cpol.
- DONE (one cycle): txc=1, transfor=0, rxb loaded with the received word. Then IDLE.
- Latency: txc is high in the cycle starting 2*BIT_WIDTH*H+1 clocks after the edge that sampled set_spdr.
- rxb holds its value until the next txc.
- mosi holds the last driven bit in IDLE.
- Boundaries:
  - set_spdr while transfor=1: ignored.
  - set_spdr with spe=0: ignored.
  - spe falling in SHIFT: next cycle go to IDLE; sck=cpol, transfor=0, no txc, rxb unchanged.
  - A new set_spdr in the DONE cycle is ignored (transfor already 0; the register map gates one cycle late).
  - rst_ mid-transfer: immediate return to reset values.

Optional Feature:
SPI_LOOPBACK_EN
- Defined: adds input port loopback (1 bit). When loopback=1, the sample path takes the internally driven mosi instead of miso. The mux select is latched at transfer start.
- Undefined: port absent; sampling always from miso.

Test Plan:
- BIT_WIDTH=8, clock_rate=3'b000 (H=2), cpol=0, cpha=0, dord=0, txb=8'hA5, miso driven with 8'h3C MSB-first → mosi bits 1,0,1,0,0,1,0,1; 16 sck edges; txc at cycle 33; rxb=8'h3C; transfor high for exactly 32 cycles.
- cpol=1, cpha=1, dord=1, clock_rate=3'b100 (H=1), txb=8'h81, miso held 1 → sck idles 1; mosi LSB first; txc at cycle 17; rxb=8'hFF.
- Sweep all 8 clock_rate codes, txb=8'h00 → sck period 2H matches the table; txc at 16H+1.
- spe deasserted after edge 5 → next cycle transfor=0, sck=cpol, no txc; rxb keeps previous value; second set_spdr then completes normally.
- set_spdr pulsed at cycle 10 of an active transfer with txb=8'hFF → ignored; first word's mosi stream and rxb are unaffected.
- SPI_LOOPBACK_EN defined, loopback=1, txb=8'h5A, miso tied 0 → rxb=8'h5A for all four cpol/cpha modes.
